// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin arbiter sharing one LSU between core (m0) and debug/DMA (m1) ports.
// Optional grant locking for read-modify-write sequences is enabled by defining LSU_ARB_LOCK_EN.
module lsu_arbiter #(
   parameter int LOCK_MAX = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_m0_req,
   input  logic [31:0] i_m0_addr,
   input  logic [31:0] i_m0_wdata,
   input  logic        i_m0_wren,
   input  logic [2:0]  i_m0_func3,
   input  logic        i_m0_lock,
   input  logic        i_m1_req,
   input  logic [31:0] i_m1_addr,
   input  logic [31:0] i_m1_wdata,
   input  logic        i_m1_wren,
   input  logic [2:0]  i_m1_func3,
   input  logic        i_m1_lock,
   output logic        o_m0_gnt,
   output logic        o_m1_gnt,
   output logic        o_m0_rvalid,
   output logic        o_m1_rvalid,
   output logic [31:0] o_m0_rdata,
   output logic [31:0] o_m1_rdata,
   output logic [31:0] o_lsu_addr,
   output logic [31:0] o_st_data,
   output logic        o_lsu_wren,
   output logic [2:0]  o_func3,
   input  logic [31:0] i_ld_data,
   output logic        o_busy
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
   logic [1:0]  state_q, state_d;
   logic        last_q, pick, pick_rr, arb;
   logic [31:0] addr_q, wdata_q, rd0_q, rd1_q, cap;
   logic        wren_q;
   logic [2:0]  func3_q;
   always_comb begin
      arb     = state_q != ISSUE && (i_m0_req || i_m1_req);
      pick_rr = (i_m0_req && i_m1_req) ? ~last_q : i_m1_req;
      state_d = state_q == ISSUE ? RESP : arb ? ISSUE : IDLE;
      cap     = wren_q ? 32'd0 : i_ld_data;
   end
`ifdef LSU_ARB_LOCK_EN
   // cnt_q counts consecutive locked grants to last_q; at LOCK_MAX one RR arbitration is forced
   logic [3:0] cnt_q, cnt_d;
   logic       can_hold, win_lock;
   always_comb begin
      can_hold = cnt_q != 4'd0 && cnt_q < 4'(LOCK_MAX);
      pick     = can_hold && (last_q ? i_m1_req : i_m0_req) ? last_q : pick_rr;
      win_lock = pick ? i_m1_lock : i_m0_lock;
      cnt_d    = !arb ? cnt_q : !win_lock ? 4'd0 : (pick == last_q && can_hold) ? cnt_q + 4'd1 : 4'd1;
   end
   always_ff @(posedge i_clk) cnt_q <= i_reset ? 4'd0 : cnt_d;
`else
   logic unused_lock;
   assign pick        = pick_rr;
   assign unused_lock = ^{i_m0_lock, i_m1_lock, 4'(LOCK_MAX)};
`endif
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         wren_q  <= 1'b0;
         func3_q <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         if (arb) begin
            last_q  <= pick;
            addr_q  <= pick ? i_m1_addr : i_m0_addr;
            wdata_q <= pick ? i_m1_wdata : i_m0_wdata;
            wren_q  <= pick ? i_m1_wren : i_m0_wren;
            func3_q <= pick ? i_m1_func3 : i_m0_func3;
         end
         if (state_q == ISSUE && !last_q) rd0_q <= cap;
         if (state_q == ISSUE && last_q) rd1_q <= cap;
      end
   end
   assign o_m0_gnt    = state_q == ISSUE && !last_q;
   assign o_m1_gnt    = state_q == ISSUE && last_q;
   assign o_m0_rvalid = state_q == RESP && !last_q;
   assign o_m1_rvalid = state_q == RESP && last_q;
   assign o_m0_rdata  = rd0_q;
   assign o_m1_rdata  = rd1_q;
   assign o_lsu_addr  = addr_q;
   assign o_st_data   = wdata_q;
   assign o_lsu_wren  = wren_q && state_q == ISSUE;
   assign o_func3     = func3_q;
   assign o_busy      = state_q != IDLE;
endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: directed and randomized checks of lsu_arbiter against a transaction-level model.
module tb_lsu_arbiter;
   localparam int LOCK_MAX = 4;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   logic [1:0]  req, wren, lock;
   logic [31:0] addr[2], wdata[2];
   logic [2:0]  f3[2];
   logic [31:0] ld;
   logic        g0, g1, rv0, rv1, lw, busy;
   logic [31:0] rd0, rd1, la, sd;
   logic [2:0]  lf;
   int n_cmp = 0, n_bad = 0;

   lsu_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_m0_req(req[0]), .i_m0_addr(addr[0]), .i_m0_wdata(wdata[0]), .i_m0_wren(wren[0]),
      .i_m0_func3(f3[0]), .i_m0_lock(lock[0]),
      .i_m1_req(req[1]), .i_m1_addr(addr[1]), .i_m1_wdata(wdata[1]), .i_m1_wren(wren[1]),
      .i_m1_func3(f3[1]), .i_m1_lock(lock[1]),
      .o_m0_gnt(g0), .o_m1_gnt(g1), .o_m0_rvalid(rv0), .o_m1_rvalid(rv1),
      .o_m0_rdata(rd0), .o_m1_rdata(rd1), .o_lsu_addr(la), .o_st_data(sd),
      .o_lsu_wren(lw), .o_func3(lf), .i_ld_data(ld), .o_busy(busy)
   );

   // Model: a grant at the end of cycle c puts the transaction in issue at c+1 and response at c+2.
   int          cyc = 0, t_iss = -10, who = 0, last = 1, run = 0;
   bit          on = 0;
   logic [31:0] m_addr, m_st;
   logic        m_wren;
   logic [2:0]  m_f3;
   logic [31:0] m_rd[2];
   always @(posedge clk) begin
      int w;
      if (rst) begin
         on = 1; t_iss = -10; last = 1; run = 0;
         m_addr = 0; m_st = 0; m_wren = 0; m_f3 = 0; m_rd[0] = 0; m_rd[1] = 0;
      end else if (cyc == t_iss) begin
         m_rd[who] = m_wren ? 32'd0 : ld;
      end else if (req != 2'b00) begin
         w = (req == 2'b11) ? 1 - last : (req[1] ? 1 : 0);
`ifdef LSU_ARB_LOCK_EN
         if (run > 0 && run < LOCK_MAX && req[last]) w = last;
         run = lock[w] ? ((w == last && run > 0 && run < LOCK_MAX) ? run + 1 : 1) : 0;
`endif
         who = w; last = w; t_iss = cyc + 1;
         m_addr = addr[w]; m_st = wdata[w]; m_wren = wren[w]; m_f3 = f3[w];
      end
      cyc++;
   end

   always @(negedge clk) begin
      logic [136:0] a, e;
      if (on) begin
         a = {g0, g1, rv0, rv1, rd0, rd1, la, sd, lw, lf, busy};
         e = {cyc == t_iss && who == 0, cyc == t_iss && who == 1,
              cyc == t_iss + 1 && who == 0, cyc == t_iss + 1 && who == 1,
              m_rd[0], m_rd[1], m_addr, m_st, m_wren && cyc == t_iss, m_f3,
              cyc == t_iss || cyc == t_iss + 1};
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL cycle %0d outputs: got %h want %h", cyc, a, e);
         end
      end
   end

   task automatic step;
      @(negedge clk);
   endtask
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask
   task automatic put(input int m, input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] f);
      req[m] = 1'b1; addr[m] = a; wdata[m] = d; wren[m] = w; f3[m] = f;
   endtask
   task automatic do_reset;
      rst = 1'b1; req = 2'b00; lock = 2'b00;
      step; step;
      rst = 1'b0;
   endtask
   task automatic put_rand(input int m);
      put(m, $urandom, $urandom, 1'($urandom_range(1)), 3'($urandom_range(7)));
   endtask

   logic [31:0] seq;
   int nbusy, nboth, ng;
   initial begin
      rst = 1'b1; req = 2'b00; lock = 2'b00; wren = 2'b00; ld = 0;
      addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0; f3[0] = 0; f3[1] = 0;
      step; step;
      chk("rst_ctl", {26'd0, g0, g1, rv0, rv1, lw, busy}, 0);
      chk("rst_rdata", rd0 | rd1, 0);
      chk("rst_lsu", la | sd | {29'd0, lf}, 0);
      rst = 1'b0;
      put(0, 32'h100, 32'hDEADBEEF, 1'b1, 3'b010);
      step;
      chk("st_gnt_wren", {29'd0, g0, g1, lw}, 3'b101);
      chk("st_addr", la, 32'h100);
      chk("st_data", sd, 32'hDEADBEEF);
      req[0] = 1'b0;
      step;
      chk("st_rv_wren", {29'd0, rv0, rv1, lw}, 3'b100);
      chk("st_rdata", rd0, 0);
      step;
      do_reset;
      put(0, 32'h200, 0, 1'b0, 3'b010);
      put(1, 32'h300, 0, 1'b0, 3'b010);
      ld = 32'h1111;
      step; chk("tie_c1", {30'd0, g0, g1}, 2'b10); req[0] = 1'b0;
      step; chk("tie_c2", {29'd0, rv0, rv1, g1}, 3'b100);
      step; chk("tie_c3", {30'd0, g0, g1}, 2'b01); req[1] = 1'b0;
      step; chk("tie_c4", {30'd0, rv0, rv1}, 2'b01);
      do_reset;
      put(0, 32'h10, 0, 1'b0, 3'b000);
      put(1, 32'h20, 0, 1'b0, 3'b001);
      seq = 0; nbusy = 0; nboth = 0;
      for (int i = 0; i < 16; i++) begin
         step;
         seq = {seq[29:0], g0, g1};
         nbusy += int'(busy);
         nboth += int'(g0 && g1);
      end
      chk("rr_order", seq, 32'h84848484);
      chk("rr_busy", nbusy, 16);
      chk("rr_both_gnt", nboth, 0);
      req = 2'b00;
      step; step;
      put(1, 32'h10010000, 0, 1'b0, 3'b100);
      step;
      chk("ld_gnt", {30'd0, g0, g1}, 2'b01);
      ld = 32'h000000A5; req[1] = 1'b0;
      step;
      chk("ld_rv", {30'd0, rv0, rv1}, 2'b01);
      chk("ld_rdata", rd1, 32'hA5);
      ld = 0;
      step;
      put(0, 32'h400, 32'h1234, 1'b1, 3'b010);
      step;
      chk("abort_gnt", {31'd0, g0}, 1);
      rst = 1'b1; req[0] = 1'b0;
      step;
      chk("abort_ctl", {26'd0, g0, g1, rv0, rv1, lw, busy}, 0);
      chk("abort_regs", rd0 | rd1 | la | sd | {29'd0, lf}, 0);
      rst = 1'b0;
      put(0, 32'h500, 0, 1'b0, 3'b010);
      put(1, 32'h600, 0, 1'b0, 3'b010);
      step;
      chk("abort_tie", {30'd0, g0, g1}, 2'b10);
      req = 2'b00;
      step; step;
`ifdef LSU_ARB_LOCK_EN
      do_reset;
      put(0, 32'h700, 0, 1'b0, 3'b010);
      put(1, 32'h800, 0, 1'b0, 3'b010);
      lock[0] = 1'b1;
      seq = 0; ng = 0;
      for (int i = 0; i < 40 && ng < 6; i++) begin
         step;
         if (g0 || g1) begin
            seq = {seq[30:0], g1};
            ng++;
         end
      end
      chk("lock_count", ng, 6);
      chk("lock_order", seq, 32'b000010);
      req = 2'b00; lock = 2'b00;
      step; step;
`endif
      for (int i = 0; i < 3000; i++) begin
         step;
         for (int m = 0; m < 2; m++) begin
            if (m == 0 ? g0 : g1) begin
               if ($urandom_range(3) == 0) req[m] = 1'b0;
               else put_rand(m);
            end else if (!req[m] && $urandom_range(2) == 0) put_rand(m);
            else if (req[m] && $urandom_range(15) == 0) req[m] = 1'b0;
            lock[m] = $urandom_range(2) != 0;
         end
         ld = $urandom;
         rst = $urandom_range(199) == 0;
      end
      rst = 1'b0; req = 2'b00;
      step; step; step;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Two-port round-robin arbiter that shares the single load/store unit between two requesters.
- m0 is the core data port; m1 is the debug/DMA port.
- Each winning transaction is registered, presented to the LSU for exactly one cycle, and the load data is captured and returned with a one-cycle response pulse.
- Sits between the core/debug masters and the LSU's addr/st_data/wren/func3/ld_data interface.

Parameters:
LOCK_MAX, 4, maximum consecutive grants to one locked master (used only with LSU_ARB_LOCK_EN); range 1..15

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  synchronous active-high reset
i_m0_req / i_m1_req  input  1  transaction request
i_m0_addr / i_m1_addr  input  32  byte address
i_m0_wdata / i_m1_wdata  input  32  store data
i_m0_wren / i_m1_wren  input  1  1=store, 0=load
i_m0_func3 / i_m1_func3  input  3  access size/sign, RV32I encoding
i_m0_lock / i_m1_lock  input  1  request to keep the grant (ignored without LSU_ARB_LOCK_EN)
o_m0_gnt / o_m1_gnt  output  1  one-cycle pulse: payload was sampled
o_m0_rvalid / o_m1_rvalid  output  1  one-cycle response pulse
o_m0_rdata / o_m1_rdata  output  32  load data, valid with rvalid; 0 for stores
o_lsu_addr  output  32  to LSU address
o_st_data  output  32  to LSU store data
o_lsu_wren  output  1  to LSU write enable
o_func3  output  3  to LSU func3
i_ld_data  input  32  from LSU load data (combinational in the same cycle)
o_busy  output  1  state != IDLE

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE.
  - All outputs are 0: gnt, rvalid, rdata, lsu_addr, st_data, lsu_wren, func3, busy.
  - RR pointer last=1, so m0 wins the first tie. Lock counter = 0.
- FSM states: IDLE, ISSUE, RESP.
- Arbitration edge: the rising edge ending IDLE or RESP with at least one req high.
  - Winner: the sole requester; on a tie, the master not granted last.
  - Winner's addr/wdata/wren/func3 are latched; last is updated; next state is ISSUE.
  - No req: IDLE→IDLE, RESP→IDLE.
- ISSUE (exactly 1 cycle):
  - o_lsu_addr/o_st_data/o_func3 = latched values.
  - o_lsu_wren = latched wren; it is never high outside ISSUE.
  - o_mX_gnt = 1 for the winner only.
  - At the end of ISSUE: rdata register captures i_ld_data for loads, 0 for stores; next state RESP.
- RESP (1 cycle): o_mX_rvalid = 1 for the winner, o_mX_rdata = captured value. RESP performs an arbitration edge.
- LSU outputs hold their last values outside ISSUE; o_lsu_wren = 0.
- Timing:
  - Latency from request sampled to rvalid: 2 cycles.
  - Peak throughput: one transaction per 2 cycles; back-to-back runs ISSUE, RESP, ISSUE, RESP...
- Requester rules:
  - Payload is held stable while req is high and gnt has not been seen.
  - On seeing gnt, the requester drops req or presents the next payload by the following edge.
  - req may drop before grant; the transaction is then lost with no response.
- Both requesters continuously active: strict alternation 0,1,0,1.
- Addresses and func3 pass through unchecked; decode and misalignment are handled in the LSU.
- o_mX_rdata of the non-responding master holds its previous value; rvalid is the only qualifier.
- Reset in ISSUE or RESP: the transaction is aborted, no rvalid is issued, and o_lsu_wren is 0 from the next cycle. A store whose ISSUE edge coincides with reset is not guaranteed.

Optional Feature:
LSU_ARB_LOCK_EN
- Defined:
  - If the winner's lock was high at arbitration and its req is high at the next arbitration edge, it wins again regardless of RR.
  - Lock counter increments per consecutive locked grant; at LOCK_MAX the lock is ignored for one arbitration and normal RR applies.
  - Counter clears when the grant changes master or lock is low.
  - Used for read-modify-write sequences.
- Undefined: lock inputs are unused; pure round-robin; no lock counter is synthesized.

Test Plan:
- m0 store, addr 0x0000_0100, data 0xDEADBEEF, func3 010, m1 idle → o_lsu_wren high only in cycle 1 with o_lsu_addr=0x100, o_st_data=0xDEADBEEF; o_m0_gnt cycle 1; o_m0_rvalid cycle 2, rdata=0.
- After reset, m0 and m1 load simultaneously → m0 gnt cycle 1, rvalid cycle 2; m1 gnt cycle 3, rvalid cycle 4.
- Both req held high for 8 transactions → grant order 0,1,0,1,0,1,0,1; o_busy constantly 1; no cycle with both gnt high.
- m1 load addr 0x1001_0000, bench drives i_ld_data=0x0000_00A5 in ISSUE → o_m1_rdata=0x0000_00A5 with o_m1_rvalid; o_m0_rvalid stays 0.
- m0 store, i_reset pulsed during ISSUE → no o_m0_rvalid; next cycle all outputs 0, state IDLE; next m0/m1 tie grants m0.
- (LSU_ARB_LOCK_EN, LOCK_MAX=4) m0 lock=1, both req continuously → m0 granted 4 consecutive times, then m1, then m0.
